// File: rtl/jtdd_adpcm_enc.sv
// MSM5205-style 4-bit ADPCM encoder that records packed nibbles into paged sample memory.
// The predictor update is shared with jt5205 playback, so both sides track bit for bit.
module jtdd_adpcm_enc #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  start_page,
    input  logic [7:0]  end_page,
    input  logic [11:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    input  logic        mem_ok,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, WAIT, CALC, WRITE} state_t;

    localparam logic [10:0] STEP_TAB [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
        11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
        11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
        11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
        11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
        11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
        11'd1552
    };

    state_t             st, st_nx;
    logic [7:0]         page, page_inc;
    logic [8:0]         bcnt;
    logic               half, wrap, done_win;
    logic signed [11:0] pred, pred_nx;
    logic [5:0]         idx, idx_nx;
    logic [11:0]        sample;
    logic [3:0]         hold, code;
    logic [12:0]        step13, m0, m1, m2, delta;
    logic signed [12:0] d;
    logic signed [13:0] sum;
    logic [6:0]         adj, idx_sum;
    logic               b2, b1, b0;

    assign pcm_ready = st == WAIT;
    assign mem_we    = st == WRITE;
    assign mem_addr  = {page[6:0], bcnt};
    assign wrap      = bcnt == 9'd511;
    assign page_inc  = page + 8'd1;
    assign done_win  = st == WRITE && mem_ok && wrap && page_inc == end_page;

    // Greedy quantiser against step, step/2, step/4; delta is the matching reconstruction
    always_comb begin
        step13  = {2'b00, STEP_TAB[idx]};
        d       = $signed({sample[11], sample}) - $signed({pred[11], pred});
        m0      = d[12] ? (~d + 13'd1) : d;
        b2      = m0 >= step13;
        m1      = b2 ? m0 - step13 : m0;
        b1      = m1 >= (step13 >> 1);
        m2      = b1 ? m1 - (step13 >> 1) : m1;
        b0      = m2 >= (step13 >> 2);
        code    = {d[12], b2, b1, b0};
        delta   = (step13 >> 3) + (b2 ? step13 : 13'd0)
                + (b1 ? step13 >> 1 : 13'd0) + (b0 ? step13 >> 2 : 13'd0);
        sum     = d[12] ? 14'(pred) - 14'(delta) : 14'(pred) + 14'(delta);
        if (sum > 14'sd2047)       pred_nx = 12'sd2047;
        else if (sum < -14'sd2048) pred_nx = -12'sd2048;
        else                       pred_nx = sum[11:0];
        adj     = code[2] ? {3'b000, ({1'b0, code[1:0], 1'b0} + 4'd2)} : 7'h7F;
        idx_sum = {1'b0, idx} + adj;
        if (idx_sum[6])                idx_nx = 6'd0;
        else if (idx_sum[5:0] > 6'd48) idx_nx = 6'd48;
        else                           idx_nx = idx_sum[5:0];
    end

    always_comb begin
        st_nx = st;
        if (start)
            st_nx = (start_page == end_page) ? IDLE : WAIT;
        else if (stop)
            st_nx = IDLE;
        else begin
            case (st)
                WAIT:    if (pcm_valid) st_nx = CALC;
                CALC:    st_nx = half ? WRITE : WAIT;
                WRITE:   if (mem_ok) st_nx = done_win ? IDLE : WAIT;
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            page     <= 8'd0;
            bcnt     <= 9'd0;
            half     <= 1'b0;
            pred     <= 12'sd0;
            idx      <= 6'd0;
            sample   <= 12'd0;
            hold     <= 4'd0;
            mem_dout <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            st   <= st_nx;
            done <= 1'b0;
            if (start) begin
                page <= start_page;
                bcnt <= 9'd0;
                half <= 1'b0;
                pred <= 12'sd0;
                idx  <= 6'd0;
                busy <= start_page != end_page;
                done <= start_page == end_page;
            end else if (stop) begin
                busy <= 1'b0;
                half <= 1'b0;
            end else begin
                case (st)
                    WAIT: if (pcm_valid) sample <= pcm_in;
                    CALC: begin
                        pred <= pred_nx;
                        idx  <= idx_nx;
                        half <= ~half;
                        if (!half) hold <= code;
                        else mem_dout <= HI_FIRST ? {hold, code} : {code, hold};
                    end
                    WRITE: if (mem_ok) begin
                        bcnt <= bcnt + 9'd1;
                        if (wrap) page <= page_inc;
                        if (done_win) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdd_adpcm_enc.sv
// Bench for jtdd_adpcm_enc: directed steps with random PCM, checked against an arithmetic encoder model.
module tb_jtdd_adpcm_enc;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [7:0]  start_page, end_page;
    logic [11:0] pcm_in;
    logic        pcm_valid, pcm_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we, mem_ok, busy, done;

    jtdd_adpcm_enc #(.HI_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .start_page(start_page), .end_page(end_page),
        .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .mem_ok(mem_ok),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int STEP [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                      73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                      279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                      963, 1060, 1166, 1282, 1411, 1552};
    int ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    // reference encoder state
    int m_pred, m_idx, m_half, m_hold, m_page, m_byte, m_end;
    bit m_done;
    logic [23:0] exp_q[$], got_q[$];
    logic [23:0] first_got, last_got;
    int last_n;

    bit auto_ok = 1'b1, rand_ok = 1'b0;
    int ok_delay = 0, wait_cnt = 0, done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    // memory side: acknowledge after ok_delay cycles and log each accepted write
    initial begin
        mem_ok = 1'b0;
        forever begin
            @(negedge clk);
            mem_ok = 1'b0;
            if (mem_we && auto_ok) begin
                if (wait_cnt >= ok_delay) begin
                    mem_ok = 1'b1;
                    got_q.push_back({mem_addr, mem_dout});
                    wait_cnt = 0;
                    if (rand_ok) ok_delay = $urandom_range(0, 3);
                end else wait_cnt++;
            end else if (!mem_we) wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_sample(input int x);
        int step, dd, s, mag, code, delta, th;
        logic [23:0] e;
        step  = STEP[m_idx];
        dd    = x - m_pred;
        s     = (dd < 0) ? 1 : 0;
        mag   = s ? -dd : dd;
        code  = 0;
        delta = step / 8;
        for (int k = 0; k < 3; k++) begin
            th = step >> k;
            if (mag >= th) begin
                mag   -= th;
                code  += 4 >> k;
                delta += th;
            end
        end
        m_pred = s ? m_pred - delta : m_pred + delta;
        if (m_pred > 2047)  m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        m_idx += ADJ[code];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        code += 8 * s;
        if (m_half == 0) begin
            m_hold = code;
            m_half = 1;
        end else begin
            e = {7'(m_page), 9'(m_byte), 8'(m_hold * 16 + code)};
            exp_q.push_back(e);
            m_half = 0;
            m_byte++;
            if (m_byte == 512) begin
                m_byte = 0;
                m_page = (m_page + 1) % 256;
                if (m_page == m_end) m_done = 1'b1;
            end
        end
    endtask

    task automatic do_start(input int sp, input int ep);
        @(negedge clk);
        start_page = 8'(sp);
        end_page   = 8'(ep);
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        m_page = sp; m_end = ep; m_byte = 0; m_half = 0;
        m_pred = 0;  m_idx = 0;  m_done = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop   = 1'b0;
        m_half = 0;
    endtask

    task automatic send(input int x);
        int n = 0;
        @(negedge clk);
        pcm_in    = 12'(x);
        pcm_valid = 1'b1;
        while (!pcm_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!pcm_ready) begin
            chk("send_timeout", 32'(pcm_ready), 32'd1);
            pcm_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 pcm_valid = 1'b0;
        model_sample(x);
    endtask

    task automatic check_writes(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        last_n    = got_q.size();
        first_got = (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx;
        last_got  = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 24'hxxxxxx;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic int rnd_pcm();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) ? 2047 : -2048;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        int dc, n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pcm_valid = 1'b0; pcm_in = 12'd0;
        start_page = 8'd0; end_page = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(pcm_ready), 32'd0);
        chk("rst_addr_dout", {mem_addr, mem_dout}, 24'd0);

        // empty window: immediate done, never busy, no writes
        dc = done_cnt;
        do_start(8'h10, 8'h10);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("empty_done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_no_write", got_q.size(), 32'd0);
        chk("empty_done_cnt", done_cnt, dc + 1);

        // full-scale first samples: code 7, pred 30, idx 8, then step 34
        do_start(8'h05, 8'h06);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(pcm_ready), 32'd1);
        send(2047);
        @(posedge clk);
        @(negedge clk);
        chk("first_pred", 32'(dut.pred), 32'd30);
        chk("first_idx", 32'(dut.idx), 32'd8);
        send(2047);
        check_writes("first_pair");
        chk("pair_77", last_got, 24'h0A0077);
        do_stop();

        // random samples with random write latency
        rand_ok = 1'b1;
        do_start(8'h20, 8'h22);
        repeat (300) send(rnd_pcm());
        check_writes("random");
        do_stop();
        chk("random_stop_busy", 32'(busy), 32'd0);
        rand_ok = 1'b0;
        ok_delay = 0;

        // stop with a pending nibble, then restart from byte 0
        dc = done_cnt;
        do_start(8'h40, 8'h42);
        repeat (3) send(rnd_pcm());
        repeat (4) @(negedge clk);
        do_stop();
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check_writes("stop_pending");
        chk("stop_no_done", done_cnt, dc);
        do_start(8'h40, 8'h42);
        send(rnd_pcm());
        send(rnd_pcm());
        check_writes("restart");
        chk("restart_addr", 32'(last_got[23:8]), 32'h8000);
        do_stop();

        // withheld acknowledge: write request held stable
        auto_ok = 1'b0;
        do_start(8'h30, 8'h31);
        send(rnd_pcm());
        send(rnd_pcm());
        n = 0;
        while (!mem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_we_seen", 32'(mem_we), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_we", 32'(mem_we), 32'd1);
            chk("hold_addr_dout", {mem_addr, mem_dout}, exp_q[0]);
            chk("hold_ready", 32'(pcm_ready), 32'd0);
            @(negedge clk);
        end
        auto_ok = 1'b1;
        check_writes("held");
        do_stop();

        // full window of silence, pages 3..4
        dc = done_cnt;
        do_start(8'h03, 8'h04);
        n = 0;
        while (!m_done && n < 2000) begin
            send(0);
            n++;
        end
        check_writes("zero");
        chk("zero_n", last_n, 32'd512);
        chk("zero_first", first_got, 24'h060008);
        chk("zero_last", last_got, 24'h07FF08);
        chk("zero_done", done_cnt, dc + 1);
        chk("zero_busy", 32'(busy), 32'd0);

        // wrapping window 0xFF -> 0x00 -> end at 0x01
        rand_ok = 1'b1;
        dc = done_cnt;
        do_start(8'hFF, 8'h01);
        n = 0;
        while (!m_done && n < 3000) begin
            send(rnd_pcm());
            n++;
        end
        check_writes("wrap");
        chk("wrap_n", last_n, 32'd1024);
        chk("wrap_first_addr", 32'(first_got[23:8]), 32'hFE00);
        chk("wrap_last_addr", 32'(last_got[23:8]), 32'h01FF);
        chk("wrap_done", done_cnt, dc + 1);
        chk("wrap_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
